// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding, Booth digit type and
// the fixed operand/accumulator widths used by the multiplier.
package arith_pkg;

    localparam int unsigned OPW  = 8;   // operand width
    localparam int unsigned EXTW = 10;  // operand after sign/zero extension
    localparam int unsigned ACCW = 20;  // signed accumulator width
    localparam int unsigned NDIG = 5;   // Booth digits per operation
    localparam int unsigned CNTW = 3;   // digit counter width
    localparam int unsigned PW   = 2 * OPW;

    // Same state encoding style as the divider
    typedef enum logic [1:0] {
        MulFree = 2'd0,
        MulOn   = 2'd1,
        MulEnd  = 2'd2
    } mul_state_t;

    // Radix-4 Booth digit, range -2..2
    typedef logic signed [2:0] booth_digit_t;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder.
// Ports:
//   window : {Y[2i+1], Y[2i], Y[2i-1]} multiplier bit window
//   digit  : d_i = -2*Y[2i+1] + Y[2i] + Y[2i-1], in -2..2
module booth_recode
    import arith_pkg::*;
(
    input  logic [2:0]   window,
    output booth_digit_t digit
);

    always_comb begin
        digit = 3'sb000;
        case (window)
            3'b001, 3'b010: digit = 3'sb001;  // +1
            3'b011:         digit = 3'sb010;  // +2
            3'b100:         digit = 3'sb110;  // -2
            3'b101, 3'b110: digit = 3'sb111;  // -1
            default:        digit = 3'sb000;  // 000, 111
        endcase
    end

endmodule

// File: rtl/booth4_mul.sv
// Sequential radix-4 Booth multiplier, 8x8 -> 16, signed or unsigned.
// One Booth digit is retired per cycle, LSB digit first.
// Ports:
//   clock, reset_n    : clock, asynchronous active-low reset
//   start, is_signed  : request and operand mode, sampled when idle
//   a, b              : multiplicand, multiplier (captured on accept)
//   busy              : operation in progress
//   ready             : one-cycle pulse when p is updated
//   p                 : product, held until the next result
module booth4_mul
    import arith_pkg::*;
(
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic           is_signed,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           busy,
    output logic           ready,
    output logic [PW-1:0]  p
);

    mul_state_t               state;
    mul_state_t               state_nxt;
    logic [CNTW-1:0]          cnt;
    logic signed [ACCW-1:0]   acc;
    logic signed [ACCW-1:0]   m_sh;     // M * 4^i for the current digit
    logic [EXTW:0]            y_sh;     // {Y, 0} shifted right two bits per digit
    logic [EXTW-1:0]          m_ext_c;
    logic [EXTW-1:0]          y_ext_c;
    booth_digit_t             digit_c;
    logic signed [ACCW-1:0]   multiple_c;

    // Operand extension to 10 bits
    assign m_ext_c = is_signed ? {{(EXTW-OPW){a[OPW-1]}}, a} : {{(EXTW-OPW){1'b0}}, a};
    assign y_ext_c = is_signed ? {{(EXTW-OPW){b[OPW-1]}}, b} : {{(EXTW-OPW){1'b0}}, b};

    booth_recode u_recode (
        .window (y_sh[2:0]),
        .digit  (digit_c)
    );

    // Multiplicand multiple select: 0, +-M, +-2M (already scaled by 4^i)
    always_comb begin
        multiple_c = '0;
        case (digit_c)
            3'sb001: multiple_c = m_sh;
            3'sb010: multiple_c = m_sh <<< 1;
            3'sb111: multiple_c = -m_sh;
            3'sb110: multiple_c = -(m_sh <<< 1);
            default: multiple_c = '0;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= MulFree;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            MulFree: if (start) state_nxt = MulOn;
            MulOn:   if (cnt == '0) state_nxt = MulEnd;
            MulEnd:  state_nxt = MulFree;
            default: state_nxt = MulFree;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            acc   <= '0;
            m_sh  <= '0;
            y_sh  <= '0;
            p     <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            busy  <= (state_nxt != MulFree);
            ready <= (state == MulEnd);
            case (state)
                MulFree: begin
                    if (start) begin
                        m_sh <= {{(ACCW-EXTW){m_ext_c[EXTW-1]}}, m_ext_c};
                        y_sh <= {y_ext_c, 1'b0};
                        acc  <= '0;
                        cnt  <= CNTW'(NDIG - 1);
                    end
                end
                MulOn: begin
                    acc  <= acc + multiple_c;
                    m_sh <= m_sh <<< 2;
                    // Arithmetic shift keeps the sign of the extended multiplier
                    y_sh <= {{2{y_sh[EXTW]}}, y_sh[EXTW:2]};
                    cnt  <= cnt - CNTW'(1);
                end
                MulEnd: begin
                    p <= acc[PW-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth4_mul.sv
// Self-checking bench for booth4_mul: directed vectors, operand stability,
// mid-operation reset and a long back-to-back random run against an
// arithmetic reference model.
module tb_booth4_mul;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        ready;
    logic [15:0] p;

    int n_cmp;
    int n_err;

    booth4_mul dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .ready     (ready),
        .p         (p)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain integer multiply, truncated to 16 bits
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
        int r;
        if (s) r = int'($signed(x)) * int'($signed(y));
        else   r = int'(x) * int'(y);
        return 16'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation from idle; optional perturbation of inputs while busy
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic os,
                          input logic [15:0] exp_p, input bit perturb, input string tag);
        int cyc;
        @(negedge clock);
        a = oa; b = ob; is_signed = os; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk({tag, "/busy_rise"}, 32'(busy), 32'd1);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
            if (perturb && cyc == 2) begin
                a = ~oa; b = ob + 8'd77; is_signed = ~os; start = 1'b1;
            end
            if (perturb && cyc == 3) start = 1'b0;
        end
        chk({tag, "/latency"}, 32'(cyc), 32'd6);
        chk({tag, "/p"}, 32'(p), 32'(exp_p));
        chk({tag, "/busy_fall"}, 32'(busy), 32'd0);
        @(posedge clock); #1;
        chk({tag, "/ready_pulse"}, 32'(ready), 32'd0);
        if (perturb) begin
            repeat (3) begin
                @(posedge clock); #1;
                chk({tag, "/no_extra_ready"}, 32'(ready), 32'd0);
            end
            chk({tag, "/p_held"}, 32'(p), 32'(exp_p));
        end
    endtask

    initial begin
        int cyc;
        logic [7:0]  ra, rb;
        logic        rs;
        logic [15:0] exp_p;

        n_cmp = 0; n_err = 0;
        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;

        // Reset state
        #12;
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/ready", 32'(ready), 32'd0);
        chk("reset/p", 32'(p), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vectors
        run_op(8'd149, 8'd3,  1'b0, 16'h01BF, 1'b0, "u149x3");
        run_op(8'hFB,  8'd3,  1'b1, 16'hFFF1, 1'b0, "s-5x3");
        run_op(8'h80,  8'h80, 1'b1, 16'h4000, 1'b0, "s-128x-128");
        run_op(8'h7F,  8'h80, 1'b1, 16'hC080, 1'b0, "s127x-128");
        run_op(8'hFF,  8'hFF, 1'b0, 16'hFE01, 1'b0, "u255x255");
        run_op(8'hFF,  8'hFF, 1'b1, 16'h0001, 1'b0, "s-1x-1");
        run_op(8'h00,  8'hA5, 1'b0, 16'h0000, 1'b0, "u0xA5");

        // Operand stability and dropped start while busy
        run_op(8'hB7, 8'h5C, 1'b1, ref_mul(8'hB7, 8'h5C, 1'b1), 1'b1, "stable_s");
        run_op(8'hB7, 8'h5C, 1'b0, ref_mul(8'hB7, 8'h5C, 1'b0), 1'b1, "stable_u");

        // Mid-operation reset at digit edge k+3
        @(negedge clock);
        a = 8'd200; b = 8'd77; is_signed = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/ready", 32'(ready), 32'd0);
        chk("abort/p", 32'(p), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (8) begin
            @(posedge clock); #1;
            chk("abort/no_ready", 32'(ready), 32'd0);
        end
        run_op(8'd12, 8'd12, 1'b0, 16'h0090, 1'b0, "after_reset");

        // Back-to-back random operations with start held high
        @(negedge clock);
        ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
        a = ra; b = rb; is_signed = rs; start = 1'b1;
        exp_p = ref_mul(ra, rb, rs);
        for (int op = 0; op < 1000; op++) begin
            cyc = 0;
            do begin
                @(posedge clock); #1;
                cyc++;
            end while (ready !== 1'b1 && cyc < 20);
            chk("b2b/ready_seen", 32'(ready), 32'd1);
            if (ready !== 1'b1) break;
            if (op > 0) chk("b2b/spacing", 32'(cyc), 32'd7);
            chk("b2b/p", 32'(p), 32'(exp_p));
            // Next accept is the following edge; present its operands now
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            a = ra; b = rb; is_signed = rs;
            exp_p = ref_mul(ra, rb, rs);
            if (op == 999) start = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/booth4_mul.md
# booth4_mul

Sequential radix-4 Booth multiplier for 8-bit operands. It produces a 16-bit signed or unsigned product through a start/ready handshake. It is the multiply counterpart of the SRT radix-4 divider and sits next to it in the arithmetic unit, using the same start/ready/is_signed conventions. The datapath retires one Booth digit per cycle.

## Interface
- No parameters; widths are fixed at 8x8 -> 16.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request. Sampled only when `busy`=0.
- `is_signed` in 1: 1 = two's-complement operands; 0 = unsigned. Captured with the operands.
- `a` in 8: multiplicand. Captured on the accepting edge.
- `b` in 8: multiplier. Captured on the accepting edge.
- `busy` out 1: high from the accepting edge until the state returns to MulFree.
- `ready` out 1: one-cycle pulse; `p` is valid from this cycle on.
- `p` out 16: product. Held until the next result is written.

## Operation
- States: MulFree, MulOn, MulEnd.
  - MulFree -> MulOn: `start`=1 at an edge.
  - MulOn -> MulEnd: at the edge where `cnt`==0.
  - MulEnd -> MulFree: unconditionally.
- Accept edge actions:
  - Extend `a` and `b` to 10 bits: sign-extend if `is_signed`, zero-extend otherwise, giving M and Y.
  - Clear the 20-bit signed accumulator ACC.
  - Set `cnt` to 4.
  - Later changes on `a`, `b` and `is_signed` are ignored.
- Booth digits: d_i = -2*Y[2i+1] + Y[2i] + Y[2i-1], with Y[-1]=0 and i=0..4. Each d_i is in {-2,-1,0,1,2}.
- MulOn, one digit per edge, LSB digit first: ACC <= ACC + d_i*M*4^i. Equivalent shift-right formulations are allowed, but the arithmetic result must be identical.
- `cnt` decrements each MulOn edge.
- MulEnd edge: `p` <= ACC[15:0]. `ready` <= 1 for exactly one cycle.
- The result is exact in both modes: the signed range [-16384, 16384] and unsigned max 65025 both fit in 16 bits. No overflow or error output exists.
- A `start` seen while `busy`=1 is dropped, not queued.
- Reset values: `busy`=0, `ready`=0, `p`=0, state MulFree, `cnt`=0, ACC=0.
- Reset asserted mid-operation aborts immediately. No `ready` follows.
- With `start` held high, a new operation is accepted on the first edge spent in MulFree.

## Timing
- Accept edge k.
- Digit edges k+1..k+5. `cnt` is 4..0; the MulOn -> MulEnd transition occurs at k+5.
- MulEnd edge k+6 writes `p` and sets `ready`.
- `ready` is high from k+6 to k+7; the state is MulFree from k+6.
- Earliest next accept is k+7, concurrent with the `ready` cycle.
- Back-to-back period: 7 cycles.
- Latency from the accept edge to `ready` high: 6 cycles.
- `busy` rises at edge k and falls at edge k+6.
- `p` changes only at the MulEnd edge or on reset.

## Structure
- Shared package `arith_pkg`:
  - state encoding (MulFree=0, MulOn=1, MulEnd=2), shared style with the divider's states;
  - `booth_digit_t`: signed 3-bit type, range -2..2;
  - width constants: OPW=8, EXTW=10, ACCW=20, NDIG=5.
- Sub-module `booth_recode`, combinational: input 3-bit window {Y[2i+1], Y[2i], Y[2i-1]}; output `booth_digit_t`. It is the counterpart of the divider's quotient-select block.
- Top level holds the FSM, the `cnt` counter, ACC, the operand registers, the multiplicand multiple mux (0, +-M, +-2M) and the adder.

## Test plan
- Unsigned: `a`=149, `b`=3 -> `p`=447 (0x01BF); `ready` high exactly 6 cycles after accept, for 1 cycle.
- Signed: `a`=-5 (0xFB), `b`=3 -> `p`=0xFFF1. Signed -128*-128 -> 0x4000. Signed 127*-128 -> 0xC080.
- Unsigned: 255*255 -> 0xFE01. Same bit patterns signed: -1*-1 -> 0x0001. 0*0xA5 -> 0x0000.
- Operand stability: change `a`/`b`/`is_signed` and pulse `start` during `busy` -> result is from the originally captured operands; no extra `ready`.
- Reset: deassert `reset_n` at digit edge k+3 -> `busy`, `ready` and `p` are 0 immediately. After release, a new 12*12 request gives 0x0090 with normal latency.
- Continuous `start`=1 with random operands over 1000 operations -> every `ready` is spaced 7 cycles apart, and every `p` matches the reference model in both modes.
